hilo_muldiv_unit: RTL

//   Iterative signed multiply/divide engine for the multicycle MIPS datapath.

---
 rtl/hilo_muldiv_unit_if.sv | 43 ++++
 rtl/hilo_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_unit_if
//   Request/result bundle between the multicycle control unit and the Hi/Lo
//   multiply/divide engine.
//
//   Signals
//     start     control -> engine   one-cycle request
//     op        control -> engine   0 = mult, 1 = div
//     a_in      control -> engine   multiplicand / dividend (signed)
//     b_in      control -> engine   multiplier / divisor (signed)
//     hi_out    engine -> control   mult: product high half; div: remainder
//     lo_out    engine -> control   mult: product low half;  div: quotient
//     busy      engine -> control   operation in flight
//     done      engine -> control   one-cycle completion pulse
//     div_zero  engine -> control   last div had a zero divisor
//
//   Modports
//     master    the control unit side (drives the request)
//     slave     the engine side (drives the results)
// ----------------------------------------------------------------------------
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a_in, b_in,
        input  hi_out, lo_out, busy, done, div_zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output hi_out, lo_out, busy, done, div_zero
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// ----------------------------------------------------------------------------
// hilo_muldiv_unit
//   Iterative signed multiply/divide engine feeding the Hi/Lo registers of the
//   multicycle MIPS datapath. mult uses radix-2 Booth recoding; div is a
//   restoring divider on operand magnitudes with a final sign fix-up.
//   Sequence: IDLE -> RUN (WIDTH steps) -> FIX -> DONE -> IDLE.
//
//   Parameters
//     WIDTH     operand width (result is 2*WIDTH bits split into hi/lo)
//
//   Ports
//     clk       system clock, rising edge
//     reset     asynchronous, active-high
//     bus       slave side of hilo_muldiv_unit_if:
//                 start/op/a_in/b_in in, hi_out/lo_out/busy/done/div_zero out
// ----------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    hilo_muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_e;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic             op_q, op_d;
    logic             negQuo_q, negQuo_d;
    logic             negRem_q, negRem_d;
    logic             zeroPend_q, zeroPend_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divZero_q, divZero_d;

    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH:0]   boothSum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH-1:0] quoShift;

    // Shared step datapath. acc holds the Booth accumulator or the partial
    // remainder, q holds the multiplier or the quotient being built, and
    // mcand holds the sign-extended multiplicand or the divisor magnitude.
    // The magnitude of the most negative operand is still correct when read
    // as an unsigned WIDTH-bit value, so no extra bit is needed for it.
    always_comb begin
        aMag     = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
        bMag     = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
        remShift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        quoShift = {q_q[WIDTH-2:0], 1'b0};
        boothSum = acc_q;
        case ({q_q[0], qm1_q})
            2'b01:   boothSum = acc_q + mcand_q;
            2'b10:   boothSum = acc_q - mcand_q;
            default: boothSum = acc_q;
        endcase
    end

    // Next-state and output logic. Results reach hi/lo only in DONE, so the
    // visible outputs cannot move while an operation is in flight. A start
    // is refused while the done pulse is showing, which keeps DONE from
    // being overlapped by a new request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        op_d       = op_q;
        negQuo_d   = negQuo_q;
        negRem_d   = negRem_q;
        zeroPend_d = zeroPend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        divZero_d  = divZero_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !done_q) begin
                    op_d      = bus.op;
                    divZero_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    acc_d     = '0;
                    qm1_d     = 1'b0;
                    if (bus.op) begin
                        q_d      = aMag;
                        mcand_d  = {1'b0, bMag};
                        negQuo_d = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                        negRem_d = bus.a_in[WIDTH-1];
                        if (bus.b_in == '0) begin
                            zeroPend_d = 1'b1;
                            state_d    = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        q_d      = bus.b_in;
                        mcand_d  = {bus.a_in[WIDTH-1], bus.a_in};
                        negQuo_d = 1'b0;
                        negRem_d = 1'b0;
                        state_d  = RUN;
                    end
                end
            end

            RUN: begin
                if (!op_q) begin
                    acc_d = {boothSum[WIDTH], boothSum[WIDTH:1]};
                    q_d   = {boothSum[0], q_q[WIDTH-1:1]};
                    qm1_d = q_q[0];
                end else if (remShift >= mcand_q) begin
                    acc_d = remShift - mcand_q;
                    q_d   = {quoShift[WIDTH-1:1], 1'b1};
                end else begin
                    acc_d = remShift;
                    q_d   = quoShift;
                end
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            FIX: begin
                if (op_q) begin
                    if (negQuo_q) begin
                        q_d = -q_q;
                    end
                    if (negRem_q) begin
                        acc_d = -acc_q;
                    end
                end
                state_d = DONE;
            end

            DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
                zeroPend_d = 1'b0;
                if (zeroPend_q) begin
                    divZero_d = 1'b1;
                end else begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = q_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    // without producing a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            op_q       <= 1'b0;
            negQuo_q   <= 1'b0;
            negRem_q   <= 1'b0;
            zeroPend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            divZero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            op_q       <= op_d;
            negQuo_q   <= negQuo_d;
            negRem_q   <= negRem_d;
            zeroPend_q <= zeroPend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            divZero_q  <= divZero_d;
        end
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = divZero_q;

endmodule
